// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle for seg7_scan_driver: scan pacing, digit data in,
// active-low anode/segment drives out.
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  // No valid/ready here: every input is a level sampled on each clk_in edge,
  // and only rising edges of scan_in (while enable=1) advance the scan.
  logic                    scan_in;
  logic                    enable;
  logic [4*N_DIGITS-1:0]   value;
  logic [N_DIGITS-1:0]     dp_mask;
  logic [N_DIGITS-1:0]     anodes;
  logic [6:0]              segments;
  logic                    dp_n;
  logic [IW-1:0]           digit_idx;

  modport master (
    output scan_in, enable, value, dp_mask,
    input  anodes, segments, dp_n, digit_idx
  );

  modport slave (
    input  scan_in, enable, value, dp_mask,
    output anodes, segments, dp_n, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: steps one digit per scan_in rising edge,
// latches a whole frame on wrap, decodes hex to active-low drives.
module seg7_scan_driver #(
  parameter int N_DIGITS      = 8,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  reset,
  seg7_scan_driver_if.slave     bus
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  logic                  r_scan_q;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_frame_value;
  logic [N_DIGITS-1:0]   r_frame_dp;
  logic [N_DIGITS-1:0]   r_anodes;
  logic [6:0]            r_segments;
  logic                  r_dp_n;

  logic                  w_step;
  logic                  w_wrap;
  logic [IW-1:0]         w_idx_next;
  logic [4*N_DIGITS-1:0] w_fv_next;
  logic [N_DIGITS-1:0]   w_fdp_next;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_anodes;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'b1000000;
      4'h1: f_decode = 7'b1111001;
      4'h2: f_decode = 7'b0100100;
      4'h3: f_decode = 7'b0110000;
      4'h4: f_decode = 7'b0011001;
      4'h5: f_decode = 7'b0010010;
      4'h6: f_decode = 7'b0000010;
      4'h7: f_decode = 7'b1111000;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0010000;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b0000011;
      4'hC: f_decode = 7'b1000110;
      4'hD: f_decode = 7'b0100001;
      4'hE: f_decode = 7'b0000110;
      default: f_decode = 7'b0001110;
    endcase
  endfunction

  // Outputs are built from the next index and next frame so a step and its
  // new digit appear together one cycle later.
  always_comb begin
    w_step     = bus.scan_in & ~r_scan_q & bus.enable;
    w_idx_next = r_idx;
    if (w_step) begin
      w_idx_next = (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end
    w_wrap     = w_step && (w_idx_next == '0);
    w_fv_next  = w_wrap ? bus.value   : r_frame_value;
    w_fdp_next = w_wrap ? bus.dp_mask : r_frame_dp;
    w_nib      = w_fv_next[4*w_idx_next +: 4];
  end

  // w_lz[k]: digits k..N-1 are all zero with no decimal point lit.
  always_comb begin
    logic l_run;
    l_run = 1'b1;
    w_lz  = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      l_run   = l_run & (w_fv_next[4*k +: 4] == 4'h0) & ~w_fdp_next[k];
      w_lz[k] = l_run;
    end
    w_blank = BLANK_LEADING && (w_idx_next != '0) && w_lz[w_idx_next];
  end

  always_comb begin
    w_anodes = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_anodes[k] = ~(bus.enable && (w_idx_next == IW'(k)));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_scan_q      <= 1'b0;
      r_idx         <= '0;
      r_frame_value <= '0;
      r_frame_dp    <= '0;
      r_anodes      <= '1;
      r_segments    <= 7'b1111111;
      r_dp_n        <= 1'b1;
    end else begin
      r_scan_q      <= bus.scan_in;
      r_idx         <= w_idx_next;
      r_frame_value <= w_fv_next;
      r_frame_dp    <= w_fdp_next;
      r_anodes      <= w_anodes;
      if (!bus.enable || w_blank) begin
        r_segments <= 7'b1111111;
        r_dp_n     <= 1'b1;
      end else begin
        r_segments <= f_decode(w_nib);
        r_dp_n     <= ~w_fdp_next[w_idx_next];
      end
    end
  end

  assign bus.anodes    = r_anodes;
  assign bus.segments  = r_segments;
  assign bus.dp_n      = r_dp_n;
  assign bus.digit_idx = r_idx;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (plain and leading-zero blanking)
// driven identically and compared every cycle against a frame-level model.
module tb_seg7_scan_driver;
  localparam int N = 8;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          scan_in;
  logic          enable;
  logic [31:0]   value;
  logic [7:0]    dp_mask;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_idx;
  logic [31:0] m_fv;
  logic [7:0]  m_fdp;
  logic        m_prev;
  logic [7:0]  e_anodes;
  logic [6:0]  e_seg0, e_seg1;
  logic        e_dp0, e_dp1;
  logic [6:0]  seg_tbl [16];

  seg7_scan_driver_if #(.N_DIGITS(N)) bus0 ();
  seg7_scan_driver_if #(.N_DIGITS(N)) bus1 ();

  assign bus0.scan_in = scan_in;
  assign bus0.enable  = enable;
  assign bus0.value   = value;
  assign bus0.dp_mask = dp_mask;
  assign bus1.scan_in = scan_in;
  assign bus1.enable  = enable;
  assign bus1.value   = value;
  assign bus1.dp_mask = dp_mask;

  seg7_scan_driver #(.N_DIGITS(N), .BLANK_LEADING(1'b0)) u_dut0 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus0.slave)
  );

  seg7_scan_driver #(.N_DIGITS(N), .BLANK_LEADING(1'b1)) u_dut1 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus1.slave)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clk_in edge using the inputs the DUT will sample.
  task automatic model_update();
    logic [3:0] nib;
    bit         lead;
    if (!reset) begin
      m_idx = 0; m_fv = '0; m_fdp = '0; m_prev = 1'b0;
      e_anodes = 8'hFF; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp0 = 1'b1; e_dp1 = 1'b1;
      return;
    end
    if (scan_in && !m_prev && enable) begin
      m_idx = (m_idx + 1) % N;
      if (m_idx == 0) begin
        m_fv  = value;
        m_fdp = dp_mask;
      end
    end
    m_prev = scan_in;
    if (!enable) begin
      e_anodes = 8'hFF; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp0 = 1'b1; e_dp1 = 1'b1;
    end else begin
      nib      = 4'((m_fv >> (4 * m_idx)) & 32'hF);
      lead     = (m_idx > 0) && ((m_fv >> (4 * m_idx)) == 0) && ((m_fdp >> m_idx) == 0);
      e_anodes = ~(8'd1 << m_idx);
      e_seg0   = seg_tbl[nib];
      e_dp0    = ~m_fdp[m_idx];
      e_seg1   = lead ? 7'h7F : seg_tbl[nib];
      e_dp1    = lead ? 1'b1  : ~m_fdp[m_idx];
    end
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk_in);
    #1;
    chk("idx0",  32'(bus0.digit_idx), 32'(m_idx));
    chk("an0",   32'(bus0.anodes),    32'(e_anodes));
    chk("seg0",  32'(bus0.segments),  32'(e_seg0));
    chk("dp0",   32'(bus0.dp_n),      32'(e_dp0));
    chk("idx1",  32'(bus1.digit_idx), 32'(m_idx));
    chk("an1",   32'(bus1.anodes),    32'(e_anodes));
    chk("seg1",  32'(bus1.segments),  32'(e_seg1));
    chk("dp1",   32'(bus1.dp_n),      32'(e_dp1));
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      scan_in = 1'b1; cycle();
      scan_in = 1'b0; cycle();
    end
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b0; scan_in = 1'b0; enable = 1'b1;
    value = 32'h76543210; dp_mask = 8'h00;

    // reset held while scan_in toggles
    for (int i = 0; i < 6; i++) begin
      scan_in = ~scan_in; cycle();
    end
    chk("rst_an", 32'(bus0.anodes), 32'hFF);
    chk("rst_seg", 32'(bus0.segments), 32'h7F);
    reset = 1'b1; scan_in = 1'b0; cycle();

    // scan and wrap
    pulse(8);
    chk("wrap_idx", 32'(bus0.digit_idx), 32'd0);
    chk("wrap_d0", 32'(bus0.segments), 32'(7'b1000000));
    pulse(7);
    chk("d7_seg", 32'(bus0.segments), 32'(7'b1111000));
    chk("d7_an", 32'(bus0.anodes), 32'h7F);
    scan_in = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    scan_in = 1'b0; cycle();
    chk("held_idx", 32'(bus0.digit_idx), 32'd0);

    // frame latch
    value = 32'h00000000;
    pulse(8);
    pulse(3);
    value = 32'h88888888;
    pulse(4);
    chk("midframe_d7", 32'(bus0.segments), 32'(7'b1000000));
    pulse(1);
    chk("newframe_d0", 32'(bus0.segments), 32'(7'b0000000));
    pulse(1);
    chk("newframe_d1", 32'(bus0.segments), 32'(7'b0000000));

    // enable freeze
    pulse(4);
    enable = 1'b0; cycle();
    chk("dis_an", 32'(bus0.anodes), 32'hFF);
    pulse(3);
    chk("dis_idx", 32'(bus0.digit_idx), 32'd5);
    enable = 1'b1; cycle();
    chk("en_an", 32'(bus0.anodes), 32'hDF);
    pulse(1);
    chk("en_step", 32'(bus0.digit_idx), 32'd6);

    // leading-zero blanking
    value = 32'h00000A05; dp_mask = 8'h00;
    pulse(2);
    chk("blk_d0", 32'(bus1.segments), 32'(7'b0010010));
    pulse(2);
    chk("blk_d2", 32'(bus1.segments), 32'(7'b0001000));
    pulse(1);
    chk("blk_d3", 32'(bus1.segments), 32'h7F);
    chk("blk_an3", 32'(bus1.anodes), 32'hF7);
    dp_mask = 8'h10;
    pulse(5);
    pulse(4);
    chk("dp_d4", 32'(bus1.segments), 32'(7'b1000000));
    chk("dp_n4", 32'(bus1.dp_n), 32'd0);
    pulse(2);

    // reset coincident with a scan edge at digit 6
    scan_in = 1'b1; reset = 1'b0; cycle();
    chk("rst_mid_idx", 32'(bus0.digit_idx), 32'd0);
    reset = 1'b1; scan_in = 1'b0; cycle();
    pulse(1);
    chk("rst_first", 32'(bus0.digit_idx), 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) scan_in = ~scan_in;
      enable = ($urandom_range(0, 15) != 0);
      reset  = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 9) == 0) begin
        int nz;
        nz = $urandom_range(0, 8);
        value = $urandom();
        if (nz > 0) value = value & (32'hFFFFFFFF >> (4 * nz));
        dp_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
